// File: rtl/loader_pkg.sv
// Shared FSM states, stream framing constants and address helper for imem_loader.
// Pure declarations: no logic, no latency.
package loader_pkg;

    localparam int LEN_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_WIDTH     = 32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_HI = 3'd1,
        LEN_LO = 3'd2,
        DATA   = 3'd3,
        WRITE  = 3'd4,
        CSUM   = 3'd5,
        DONE   = 3'd6,
        ERROR  = 3'd7
    } state_t;

    // Byte address of word 'index'; 32-bit arithmetic wraps modulo 2^32.
    function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] index);
        return base + (index << 2);
    endfunction

endpackage

// File: rtl/word_assembler.sv
// Big-endian byte-to-word assembler: flags the byte that completes a word, same cycle.
// No backpressure of its own; the caller only raises i_byte_vld on accepted bytes.
module word_assembler
    import loader_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_clear,
    input  logic                  i_byte_vld,
    input  logic [7:0]            i_byte_dat,
    output logic [WORD_WIDTH-1:0] o_word,
    output logic                  o_word_complete
);

    localparam int CNT_W = $clog2(BYTES_PER_WORD);

    // Three bytes are buffered; the fourth is appended combinationally so the
    // full word is available on the edge that accepts it.
    logic [WORD_WIDTH-9:0] r_shift;
    logic [CNT_W-1:0]      r_cnt;

    assign o_word          = {r_shift, i_byte_dat};
    assign o_word_complete = i_byte_vld && (r_cnt == CNT_W'(BYTES_PER_WORD - 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (i_clear) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (i_byte_vld) begin
            r_shift <= o_word[WORD_WIDTH-9:0];
            r_cnt   <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Serial program loader: length-prefixed big-endian words into instruction memory, 5 cycles/word min.
// rx_ready only in LEN_HI/LEN_LO/DATA/CSUM; LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
module imem_loader
    import loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 256
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        mem_write_enabled,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data,
    output logic        cpu_reset,
    output logic        done,
    output logic        err_overflow,
    output logic        err_checksum
);

    localparam int IDX_W = $clog2(MAX_WORDS + 1);
    localparam int LEN_W = 8 * LEN_BYTES;

`ifdef LOADER_CHECKSUM_EN
    localparam state_t END_STATE = CSUM;
`else
    localparam state_t END_STATE = DONE;
`endif

    state_t                r_state;
    logic [7:0]            r_len_hi;
    logic [IDX_W-1:0]      r_len;
    logic [IDX_W-1:0]      r_index;
    logic [31:0]           r_mem_address;
    logic [31:0]           r_mem_data;
    logic                  r_err_overflow;

    logic                  w_xfer;
    logic                  w_byte_vld;
    logic                  w_start_load;
    logic [LEN_W-1:0]      w_len;
    logic                  w_too_long;
    logic [IDX_W-1:0]      w_idx_inc;
    logic [WORD_WIDTH-1:0] w_word;
    logic                  w_word_complete;

    assign rx_ready = (r_state == LEN_HI) || (r_state == LEN_LO) ||
                      (r_state == DATA)   || (r_state == CSUM);
    assign w_xfer       = rx_valid && rx_ready;
    assign w_byte_vld   = w_xfer && (r_state == DATA);
    assign w_start_load = start && ((r_state == IDLE) || (r_state == DONE) || (r_state == ERROR));
    assign w_len        = {r_len_hi, rx_data};
    assign w_too_long   = 32'(w_len) > 32'(MAX_WORDS);
    assign w_idx_inc    = r_index + IDX_W'(1);

    assign mem_write_enabled = (r_state == WRITE);
    assign mem_address       = r_mem_address;
    assign mem_data          = r_mem_data;
    assign done              = (r_state == DONE);
    assign cpu_reset         = (r_state != DONE);
    assign err_overflow      = r_err_overflow;

    word_assembler u_word_assembler (
        .i_clk           (clock),
        .i_rst           (reset),
        .i_clear         (w_start_load),
        .i_byte_vld      (w_byte_vld),
        .i_byte_dat      (rx_data),
        .o_word          (w_word),
        .o_word_complete (w_word_complete)
    );

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] r_csum;
    logic       r_err_checksum;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_csum         <= '0;
            r_err_checksum <= 1'b0;
        end else if (w_start_load) begin
            r_csum         <= '0;
            r_err_checksum <= 1'b0;
        end else begin
            if (w_byte_vld) begin
                r_csum <= r_csum ^ rx_data;
            end
            if ((r_state == CSUM) && w_xfer && (rx_data != r_csum)) begin
                r_err_checksum <= 1'b1;
            end
        end
    end

    assign err_checksum = r_err_checksum;
`else
    assign err_checksum = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state        <= IDLE;
            r_len_hi       <= '0;
            r_len          <= '0;
            r_index        <= '0;
            r_mem_address  <= BASE_ADDR;
            r_mem_data     <= '0;
            r_err_overflow <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        r_state        <= LEN_HI;
                        r_index        <= '0;
                        r_err_overflow <= 1'b0;
                    end
                end
                LEN_HI: begin
                    if (w_xfer) begin
                        r_len_hi <= rx_data;
                        r_state  <= LEN_LO;
                    end
                end
                LEN_LO: begin
                    if (w_xfer) begin
                        r_len <= w_len[IDX_W-1:0];
                        if (w_too_long) begin
                            r_state        <= ERROR;
                            r_err_overflow <= 1'b1;
                        end else if (w_len == '0) begin
                            r_state <= END_STATE;
                        end else begin
                            r_state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (w_word_complete) begin
                        r_state       <= WRITE;
                        r_mem_address <= word_addr(BASE_ADDR, 32'(r_index));
                        r_mem_data    <= w_word;
                    end
                end
                WRITE: begin
                    r_index <= w_idx_inc;
                    r_state <= (w_idx_inc == r_len) ? END_STATE : DATA;
                end
                CSUM: begin
`ifdef LOADER_CHECKSUM_EN
                    if (w_xfer) begin
                        r_state <= (rx_data == r_csum) ? DONE : ERROR;
                    end
`else
                    r_state <= DONE;
`endif
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
